mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-side stage directly downstream of the multi-cycle controller. Consumes MemRead, MemWrite, IorD and IRWrite.
- Runs each access as a req/ready handshake against a variable-latency word memory.
- Holds the Instruction Register (IR) and Memory Data Register (MDR). Supplies OpCode/Funct back to the controller.
- Raises Stall so the controller holds its state until the access completes.

Parameters:
- MEM_AW, 8, word-address width of the memory port; the memory is 2^MEM_AW words of 32 bits.
- TIMEOUT, 16, WAIT cycles without mem_ready before the access is aborted; legal range 2..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- MemRead  input  1  controller read strobe.
- MemWrite  input  1  controller write strobe.
- IorD  input  1  address select: 0 = PC, 1 = ALUOut.
- IRWrite  input  1  the read data is loaded into IR as well as MDR.
- PC  input  32  instruction address.
- ALUOut  input  32  data address.
- WriteData  input  32  store data (B register).
- Stall  output  1  controller must hold state while high.
- Instruction  output  32  IR contents.
- OpCode  output  6  IR[31:26].
- Funct  output  6  IR[5:0].
- MemData  output  32  MDR contents.
- bus_err  output  1  sticky error flag: timeout or misaligned address.
- mem_req  output  1  memory request.
- mem_we  output  1  write enable; valid while mem_req is high.
- mem_addr  output  MEM_AW  word address.
- mem_wdata  output  32  write data.
- mem_rdata  input  32  read data; valid when mem_ready is high.
- mem_ready  input  1  completion of the current request.

Behaviour:
- FSM states: IDLE, WAIT.
- Reset values: state=IDLE, IR=0, MDR=0, bus_err=0, timeout counter=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- acc = MemRead | MemWrite. addr = IorD ? ALUOut : PC.
- IDLE, acc=1, addr[1:0]==0:
  - Latch the following into registers: mem_addr = addr[MEM_AW+1:2], mem_wdata = WriteData, we = MemWrite, irw = IRWrite & ~MemWrite.
  - Go to WAIT and clear the counter.
  - Stall=1 combinationally in this cycle.
- IDLE, acc=1, addr[1:0]!=0:
  - No request is issued. Set bus_err and stay in IDLE.
  - Stall=0, so the controller proceeds. IR and MDR are unchanged.
- MemRead and MemWrite both high: the write wins, the access is treated as a store, and bus_err is set.
- WAIT:
  - mem_req=1 and mem_we=we; registered, so mem_req is first high the cycle after the request.
  - Stall = ~mem_ready.
- WAIT, mem_ready=1:
  - For a read, MDR <= mem_rdata, and IR <= mem_rdata if irw is set.
  - Next state IDLE; new IR/MDR values are visible the following cycle.
  - Minimum access time is 2 cycles: 1 stalled cycle plus the ready cycle.
- WAIT, no ready:
  - The counter increments each cycle.
  - When the counter reaches TIMEOUT-1, abort: bus_err=1, go to IDLE, Stall=0 in that cycle, IR/MDR unchanged.
- Back-to-back accesses: the controller's next state may assert acc in the cycle immediately after completion. This starts a fresh request from IDLE with no bubble beyond the 1 stalled IDLE cycle.
- mem_ready in IDLE is ignored.
- Reset in WAIT: go to IDLE on the edge and drop mem_req the next cycle. A late mem_ready is ignored.
- bus_err is cleared only by reset.
- OpCode and Funct are continuous slices of IR.

Decomposition:
- Shared package contents:
  - state encoding constants (IDLE=1'b0, WAIT=1'b1).
  - instruction field bit positions (OPCODE 31:26, FUNCT 5:0, RS, RT, RD, SHAMT, IMM16).
  - the opcode constants already used by the controller (6'h00, 6'h04, 6'h0a, 6'h0b, 6'h0c).
- No sub-module: FSM, counter and the two registers fit in one module.

Test Plan:
- Fetch: PC=0x10, MemRead=1, IorD=0, IRWrite=1, memory returns 0x3C011234 with ready on the first WAIT cycle.
  - Required: Stall high for exactly 1 cycle, mem_addr=4, mem_we=0.
  - Next cycle: Instruction=0x3C011234, OpCode=6'h0F, MDR=0x3C011234.
- Store with 3-cycle memory latency: ALUOut=0x20, IorD=1, MemWrite=1, WriteData=0xDEADBEEF.
  - Required: mem_req high 3 cycles with mem_we=1, mem_addr=8, mem_wdata=0xDEADBEEF, Stall high 3 cycles, IR/MDR unchanged.
- Load, IRWrite=0: data 0x000000FF arrives.
  - Required: MDR=0x000000FF, IR keeps its prior value.
- Timeout: TIMEOUT=4, mem_ready held 0.
  - Required: abort after 4 WAIT cycles, bus_err=1, Stall drops in the abort cycle, a subsequent good read succeeds with bus_err still 1.
- Misaligned: ALUOut=0x22, IorD=1, MemRead=1.
  - Required: mem_req never asserts, Stall=0, bus_err=1 next cycle.
- Reset asserted in the 2nd WAIT cycle.
  - Required: mem_req=0 and all outputs at reset values the cycle after the reset edge. A mem_ready pulse one cycle later leaves IR/MDR at 0.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access stage: FSM encoding, instruction
// field positions and the opcodes the controller decodes.
`timescale 1ns/1ps
package mem_access_unit_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StWait = 1'b1
  } state_e;

  localparam int unsigned OpcodeMsb = 31;
  localparam int unsigned OpcodeLsb = 26;
  localparam int unsigned RsMsb     = 25;
  localparam int unsigned RsLsb     = 21;
  localparam int unsigned RtMsb     = 20;
  localparam int unsigned RtLsb     = 16;
  localparam int unsigned RdMsb     = 15;
  localparam int unsigned RdLsb     = 11;
  localparam int unsigned ShamtMsb  = 10;
  localparam int unsigned ShamtLsb  = 6;
  localparam int unsigned FunctMsb  = 5;
  localparam int unsigned FunctLsb  = 0;
  localparam int unsigned Imm16Msb  = 15;
  localparam int unsigned Imm16Lsb  = 0;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpSlti  = 6'h0a;
  localparam logic [5:0] OpSltiu = 6'h0b;
  localparam logic [5:0] OpAndi  = 6'h0c;

  function automatic logic [5:0] get_opcode(input logic [31:0] instr);
    return instr[OpcodeMsb:OpcodeLsb];
  endfunction

  function automatic logic [5:0] get_funct(input logic [31:0] instr);
    return instr[FunctMsb:FunctLsb];
  endfunction

endpackage

// File: rtl/mem_access_unit.sv
// Memory-side stage of the multi-cycle datapath: runs each controller access as
// a req/ready handshake, holds IR and MDR, and stalls the controller meanwhile.
`timescale 1ns/1ps
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned MEM_AW  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              IorD,
  input  logic              IRWrite,
  input  logic [31:0]       PC,
  input  logic [31:0]       ALUOut,
  input  logic [31:0]       WriteData,
  output logic              Stall,
  output logic [31:0]       Instruction,
  output logic [5:0]        OpCode,
  output logic [5:0]        Funct,
  output logic [31:0]       MemData,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e            r_state;
  logic [7:0]        r_cnt;
  logic              r_irw;
  logic [31:0]       r_ir;
  logic [31:0]       r_mdr;
  logic              r_bus_err;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [MEM_AW-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;

  logic              w_acc;
  logic [31:0]       w_addr;
  logic              w_aligned;
  logic              w_cnt_last;
  logic              w_stall;
  logic              w_unused;

  assign w_acc      = MemRead | MemWrite;
  assign w_addr     = IorD ? ALUOut : PC;
  assign w_aligned  = (w_addr[1:0] == 2'b00);
  assign w_cnt_last = (r_cnt == CntLast);
  // Address bits above the memory window are intentionally ignored.
  assign w_unused   = ^w_addr[31:MEM_AW+2];

  // Stall: issuing cycle in IDLE, and every WAIT cycle that neither completes nor aborts.
  always_comb begin
    w_stall = 1'b0;
    unique case (r_state)
      StIdle:  w_stall = w_acc & w_aligned;
      StWait:  w_stall = ~mem_ready & ~w_cnt_last;
      default: w_stall = 1'b0;
    endcase
  end

  // FSM, timeout counter, request registers, IR/MDR and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_cnt       <= 8'd0;
      r_irw       <= 1'b0;
      r_ir        <= 32'd0;
      r_mdr       <= 32'd0;
      r_bus_err   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_acc) begin
            if (w_aligned) begin
              r_mem_addr  <= w_addr[MEM_AW+1:2];
              r_mem_wdata <= WriteData;
              r_mem_we    <= MemWrite;
              // A write wins over a simultaneous read, so it never loads IR.
              r_irw       <= IRWrite & ~MemWrite;
              r_mem_req   <= 1'b1;
              r_cnt       <= 8'd0;
              r_state     <= StWait;
              if (MemRead && MemWrite) begin
                r_bus_err <= 1'b1;
              end
            end else begin
              r_bus_err <= 1'b1;
            end
          end
        end
        StWait: begin
          if (mem_ready) begin
            if (!r_mem_we) begin
              r_mdr <= mem_rdata;
              if (r_irw) begin
                r_ir <= mem_rdata;
              end
            end
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_state   <= StIdle;
          end else if (w_cnt_last) begin
            r_bus_err <= 1'b1;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_state   <= StIdle;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign Stall       = w_stall;
  assign Instruction = r_ir;
  assign OpCode      = get_opcode(r_ir);
  assign Funct       = get_funct(r_ir);
  assign MemData     = r_mdr;
  assign bus_err     = r_bus_err;
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit with a variable-latency memory.
`timescale 1ns/1ps
module tb_mem_access_unit;

  localparam int unsigned AW    = 8;
  localparam int          TO    = 4;
  localparam int          NEVER = 99;

  logic          clk = 1'b0;
  logic          reset;
  logic          MemRead, MemWrite, IorD, IRWrite;
  logic [31:0]   PC, ALUOut, WriteData;
  logic          Stall;
  logic [31:0]   Instruction;
  logic [5:0]    OpCode, Funct;
  logic [31:0]   MemData;
  logic          bus_err;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          mem_ready;

  mem_access_unit #(.MEM_AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .IRWrite(IRWrite), .PC(PC), .ALUOut(ALUOut), .WriteData(WriteData), .Stall(Stall),
    .Instruction(Instruction), .OpCode(OpCode), .Funct(Funct), .MemData(MemData),
    .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          stall;
    int          req;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [256];
  logic [31:0] phys    [256];
  logic [31:0] m_ir, m_mdr;
  logic        m_err;
  int          cfg_delay = 0;
  bit          noise_en  = 1'b0;
  bit          force_pulse = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder: ready after cfg_delay WAIT cycles, never if cfg_delay is NEVER.
  initial begin
    int wcnt;
    wcnt = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (force_pulse) begin
        mem_ready   = 1'b1;
        mem_rdata   = 32'hFFFF_FFFF;
        force_pulse = 1'b0;
      end else if (mem_req) begin
        if (cfg_delay != NEVER && wcnt == cfg_delay) begin
          mem_ready = 1'b1;
          if (mem_we) begin
            phys[mem_addr] = mem_wdata;
            mem_rdata = $urandom;
          end else begin
            mem_rdata = phys[mem_addr];
          end
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
        end
        wcnt++;
      end else begin
        wcnt      = 0;
        mem_ready = noise_en && ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor: an access retires on the cycle the controller holds acc with Stall low.
  initial begin
    int   mon_stall;
    int   mon_req;
    bit   post;
    exp_t cur;
    mon_stall = 0;
    mon_req   = 0;
    post      = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_stall = 0;
        mon_req   = 0;
        post      = 1'b0;
      end else begin
        if (post) begin
          chk("ir", Instruction, cur.ir);
          chk("mdr", MemData, cur.mdr);
          chk("opcode", {26'd0, OpCode}, cur.ir >> 26);
          chk("funct", {26'd0, Funct}, cur.ir & 32'h3F);
          chk("bus_err", {31'd0, bus_err}, {31'd0, cur.err});
          post = 1'b0;
        end
        if (mem_req) mon_req++;
        if ((MemRead || MemWrite) && Stall) mon_stall++;
        if ((MemRead || MemWrite) && !Stall) begin
          if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
          end else begin
            cur = sb.pop_front();
            chk("stall_cycles", 32'(mon_stall), 32'(cur.stall));
            chk("req_cycles", 32'(mon_req), 32'(cur.req));
            if (cur.req > 0) begin
              chk("mem_addr", {24'd0, mem_addr}, cur.addr);
              chk("mem_we", {31'd0, mem_we}, {31'd0, cur.we});
              if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
            end
            post = 1'b1;
          end
          mon_stall = 0;
          mon_req   = 0;
        end
      end
    end
  end

  // Reference model of one access, then drive it and hold until Stall drops.
  task automatic access(input logic rd, input logic wr, input logic iord, input logic irw,
                        input logic [31:0] pc, input logic [31:0] alu,
                        input logic [31:0] wd, input int delay);
    exp_t        e;
    logic [31:0] a;
    int          w;
    a       = iord ? alu : pc;
    w       = int'((a >> 2) % 256);
    e.stall = 0;
    e.req   = 0;
    e.addr  = 32'(w);
    e.we    = wr;
    e.wdata = wd;
    if ((a % 4) != 0) begin
      m_err = 1'b1;
    end else begin
      if (rd && wr) m_err = 1'b1;
      if (delay <= TO - 1) begin
        e.stall = delay + 1;
        e.req   = delay + 1;
        if (wr) begin
          ref_mem[w] = wd;
        end else begin
          m_mdr = ref_mem[w];
          if (irw) m_ir = ref_mem[w];
        end
      end else begin
        e.stall = TO;
        e.req   = TO;
        m_err   = 1'b1;
      end
    end
    e.ir  = m_ir;
    e.mdr = m_mdr;
    e.err = m_err;
    sb.push_back(e);

    cfg_delay = delay;
    MemRead   = rd;
    MemWrite  = wr;
    IorD      = iord;
    IRWrite   = irw;
    PC        = pc;
    ALUOut    = alu;
    WriteData = wd;
    for (int c = 0; ; c++) begin
      @(negedge clk);
      if (!Stall) break;
      if (c > 20) begin
        chk("stall_bound", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  task automatic gap(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_access();
    int          k;
    int          d;
    logic        rd, wr, iord, irw;
    logic [31:0] a;
    k = int'($urandom_range(0, 9));
    d = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 3));
    a = $urandom & 32'hFFFF_FFFC;
    rd   = 1'b1;
    wr   = 1'b0;
    iord = 1'b1;
    irw  = 1'($urandom_range(0, 1));
    if (k == 0) begin
      a  = a | 32'($urandom_range(1, 3));
      wr = 1'($urandom_range(0, 1));
      rd = ~wr;
    end else if (k == 1) begin
      wr = 1'b1;
    end else if (k <= 3) begin
      rd = 1'b0;
      wr = 1'b1;
    end else if (k <= 6) begin
      iord = 1'b0;
      irw  = 1'b1;
    end
    access(rd, wr, iord, irw, iord ? $urandom : a, iord ? a : $urandom, $urandom, d);
    gap(int'($urandom_range(0, 2)));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_stall"}, {31'd0, Stall}, 32'd0);
    chk({tag, "_ir"}, Instruction, 32'd0);
    chk({tag, "_mdr"}, MemData, 32'd0);
    chk({tag, "_err"}, {31'd0, bus_err}, 32'd0);
    chk({tag, "_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_addr"}, {24'd0, mem_addr}, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
  endtask

  task automatic reset_in_wait();
    noise_en = 1'b0;
    gap(3);
    cfg_delay = NEVER;
    MemRead   = 1'b1;
    IorD      = 1'b1;
    IRWrite   = 1'b1;
    ALUOut    = 32'h100;
    @(negedge clk);
    chk("rst_idle_stall", {31'd0, Stall}, 32'd1);
    gap(2);
    chk("rst_wait2_req", {31'd0, mem_req}, 32'd1);
    reset   = 1'b1;
    MemRead = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_wait");
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_ir  = 32'd0;
    m_mdr = 32'd0;
    m_err = 1'b0;
    @(negedge clk);
    force_pulse = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("late_ready_ir", Instruction, 32'd0);
    chk("late_ready_mdr", MemData, 32'd0);
    chk("late_ready_req", {31'd0, mem_req}, 32'd0);
    noise_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 32'(i) * 32'h9E37_79B9 ^ 32'h5A5A_0000;
      phys[i]    = ref_mem[i];
    end
    m_ir = 32'd0;
    m_mdr = 32'd0;
    m_err = 1'b0;
    reset = 1'b1;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    IorD = 1'b0;
    IRWrite = 1'b0;
    PC = 32'd0;
    ALUOut = 32'd0;
    WriteData = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed scenarios.
    phys[4]    = 32'h3C01_1234;
    ref_mem[4] = 32'h3C01_1234;
    access(1'b1, 1'b0, 1'b0, 1'b1, 32'h10, $urandom, $urandom, 0);
    access(1'b0, 1'b1, 1'b1, 1'b0, $urandom, 32'h20, 32'hDEAD_BEEF, 2);
    phys[16]    = 32'h0000_00FF;
    ref_mem[16] = 32'h0000_00FF;
    access(1'b1, 1'b0, 1'b1, 1'b0, $urandom, 32'h40, $urandom, 1);
    access(1'b1, 1'b0, 1'b1, 1'b1, $urandom, 32'h80, $urandom, NEVER);
    access(1'b1, 1'b0, 1'b0, 1'b1, 32'h10, $urandom, $urandom, 0);
    access(1'b1, 1'b0, 1'b1, 1'b0, $urandom, 32'h22, $urandom, 0);
    gap(2);

    noise_en = 1'b1;
    for (int i = 0; i < 120; i++) rand_access();
    reset_in_wait();
    for (int i = 0; i < 120; i++) rand_access();

    gap(4);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
